// File: rtl/onehot_pkg.sv
// rtl/onehot_pkg.sv - shared skid-buffer state type and error counter width
package onehot_pkg;

  localparam int ERR_CNT_W = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/onehot_decoder_if.sv
// rtl/onehot_decoder_if.sv - index-in / one-hot-out handshake bundle
interface onehot_decoder_if #(
  parameter int INPUT_W  = 2,
  parameter int OUTPUT_W = 3
);
  import onehot_pkg::*;

  logic                 i_valid;
  logic                 i_ready;
  logic [INPUT_W-1:0]   i;
  logic                 o_valid;
  logic                 o_ready;
  logic [OUTPUT_W-1:0]  o;
  logic                 o_err;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output i_valid, i, o_ready,
    input  i_ready, o_valid, o, o_err, err_cnt
  );

  modport slave (
    input  i_valid, i, o_ready,
    output i_ready, o_valid, o, o_err, err_cnt
  );

endinterface

// File: rtl/onehot_decoder_skid_buffer.sv
// rtl/onehot_decoder_skid_buffer.sv - two-entry skid buffer with registered ready
module skid_buffer #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready
);
  import onehot_pkg::*;

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              ready_q, ready_d;
  logic              in_xfer;
  logic              out_xfer;

  assign in_xfer  = s_tvalid && ready_q;
  assign out_xfer = (state_q != EMPTY) && m_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d = ONE;
          head_d  = s_tdata;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          head_d = s_tdata;
        end else if (in_xfer) begin
          state_d = FULL;
          skid_d  = s_tdata;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // Ready is low here, so only the drain side can move.
        if (out_xfer) begin
          state_d = ONE;
          head_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    ready_d = (state_d != FULL);
  end

  always_comb begin
    s_tready = ready_q;
    m_tvalid = (state_q != EMPTY);
    m_tdata  = m_tvalid ? head_q : '0;
  end

endmodule

// File: rtl/onehot_decoder.sv
// rtl/onehot_decoder.sv - registered binary-to-one-hot decoder with range error count
module onehot_decoder #(
  parameter int INPUT_W  = 2,
  parameter int OUTPUT_W = 3
) (
  input  logic          clk,
  input  logic          rst,
  onehot_decoder_if.slave bus
);
  import onehot_pkg::*;

  localparam logic [INPUT_W:0] OUT_LIM = (INPUT_W + 1)'(OUTPUT_W);

  logic [OUTPUT_W-1:0]  dec_word;
  logic                 dec_err;
  logic                 in_xfer;
  logic [OUTPUT_W:0]    buf_data;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    dec_err  = ({1'b0, bus.i} >= OUT_LIM);
    dec_word = dec_err ? '0 : (OUTPUT_W'(1) << bus.i);
  end

  assign in_xfer = bus.i_valid && bus.i_ready;

  skid_buffer #(
    .DATA_W (OUTPUT_W + 1)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .s_tdata  ({dec_err, dec_word}),
    .s_tvalid (bus.i_valid),
    .s_tready (bus.i_ready),
    .m_tdata  (buf_data),
    .m_tvalid (bus.o_valid),
    .m_tready (bus.o_ready)
  );

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (in_xfer && dec_err && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.o       = buf_data[OUTPUT_W-1:0];
  assign bus.o_err   = buf_data[OUTPUT_W];
  assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_onehot_decoder.sv
// tb/tb_onehot_decoder.sv - directed and randomized checks for onehot_decoder
module tb_onehot_decoder;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  onehot_decoder_if #(.INPUT_W(2), .OUTPUT_W(3)) bus ();

  onehot_decoder #(.INPUT_W(2), .OUTPUT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] ref_word(input logic [1:0] idx);
    logic [3:0] w;
    case (idx)
      2'd0:    w = 4'b0001;
      2'd1:    w = 4'b0010;
      2'd2:    w = 4'b0100;
      default: w = 4'b1000;
    endcase
    return w;
  endfunction

  logic [3:0] exp_q[$];
  logic [3:0] exp_w;
  int         ref_err;
  bit         in_x;
  bit         out_x;

  initial begin
    errors      = 0;
    checks      = 0;
    rst         = 1'b1;
    bus.i_valid = 1'b0;
    bus.i       = 2'd0;
    bus.o_ready = 1'b0;

    // reset values while rst is held
    #2;
    chk("rst_o_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_i_ready", 32'(bus.i_ready), 32'd0);
    chk("rst_o", 32'(bus.o), 32'd0);
    chk("rst_o_err", 32'(bus.o_err), 32'd0);
    chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("rel_i_ready", 32'(bus.i_ready), 32'd1);

    // streaming 0,1,2
    bus.o_ready = 1'b1;
    bus.i_valid = 1'b1;
    bus.i = 2'd0;
    step();
    chk("str0_o", 32'(bus.o), 32'b001);
    chk("str0_valid", 32'(bus.o_valid), 32'd1);
    bus.i = 2'd1;
    step();
    chk("str1_o", 32'(bus.o), 32'b010);
    chk("str1_err", 32'(bus.o_err), 32'd0);
    bus.i = 2'd2;
    step();
    chk("str2_o", 32'(bus.o), 32'b100);
    chk("str2_err", 32'(bus.o_err), 32'd0);
    bus.i_valid = 1'b0;
    step();
    chk("str_drain_valid", 32'(bus.o_valid), 32'd0);

    // out of range
    bus.i_valid = 1'b1;
    bus.i = 2'd3;
    step();
    chk("oor_o", 32'(bus.o), 32'd0);
    chk("oor_err", 32'(bus.o_err), 32'd1);
    chk("oor_cnt", 32'(bus.err_cnt), 32'd1);
    bus.i_valid = 1'b0;
    step();

    // backpressure
    bus.o_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.i = 2'd0;
    step();
    chk("bp_ready1", 32'(bus.i_ready), 32'd1);
    chk("bp_o1", 32'(bus.o), 32'b001);
    bus.i = 2'd1;
    step();
    chk("bp_ready2", 32'(bus.i_ready), 32'd0);
    chk("bp_hold_o", 32'(bus.o), 32'b001);
    bus.i = 2'd2;
    step();
    chk("bp_hold_o2", 32'(bus.o), 32'b001);
    chk("bp_hold_valid", 32'(bus.o_valid), 32'd1);
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b1;
    step();
    chk("bp_second", 32'(bus.o), 32'b010);
    chk("bp_second_valid", 32'(bus.o_valid), 32'd1);
    chk("bp_ready_back", 32'(bus.i_ready), 32'd1);
    step();
    chk("bp_empty", 32'(bus.o_valid), 32'd0);

    // mid-stream reset with two buffered words
    bus.o_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.i = 2'd3;
    step();
    bus.i = 2'd1;
    step();
    bus.i_valid = 1'b0;
    chk("pre_rst_full", 32'(bus.i_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.o_valid), 32'd0);
    chk("mid_rst_cnt", 32'(bus.err_cnt), 32'd0);
    chk("mid_rst_o", 32'(bus.o), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_ready", 32'(bus.i_ready), 32'd1);
    chk("post_rst_valid", 32'(bus.o_valid), 32'd0);
    chk("post_rst_cnt", 32'(bus.err_cnt), 32'd0);

    // saturation
    bus.o_ready = 1'b1;
    bus.i_valid = 1'b1;
    bus.i = 2'd3;
    for (int n = 1; n <= 260; n++) begin
      step();
      if (n == 254) chk("sat_254", 32'(bus.err_cnt), 32'd254);
      if (n == 255) chk("sat_255", 32'(bus.err_cnt), 32'd255);
    end
    chk("sat_260", 32'(bus.err_cnt), 32'd255);
    bus.i_valid = 1'b0;
    step();

    // random valid/ready against a reference queue
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    ref_err = 0;
    for (int c = 0; c < 10000; c++) begin
      bus.i_valid = ($urandom_range(0, 3) != 0);
      bus.i       = 2'($urandom_range(0, 3));
      bus.o_ready = ($urandom_range(0, 2) != 0);
      in_x  = bus.i_valid && bus.i_ready;
      out_x = bus.o_valid && bus.o_ready;
      if (out_x) begin
        if (exp_q.size() == 0) begin
          chk("rnd_dup", 32'd1, 32'd0);
        end else begin
          exp_w = exp_q.pop_front();
          chk("rnd_word", 32'({bus.o_err, bus.o}), 32'(exp_w));
        end
      end
      if (in_x) begin
        exp_q.push_back(ref_word(bus.i));
        if (bus.i == 2'd3 && ref_err < 255) ref_err++;
      end
      step();
    end
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (bus.o_valid) begin
        if (exp_q.size() == 0) begin
          chk("drain_dup", 32'd1, 32'd0);
        end else begin
          exp_w = exp_q.pop_front();
          chk("drain_word", 32'({bus.o_err, bus.o}), 32'(exp_w));
        end
      end
      step();
    end
    chk("rnd_no_drop", 32'(exp_q.size()), 32'd0);
    chk("rnd_err_cnt", 32'(bus.err_cnt), 32'(ref_err));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
